// File: rtl/bounce_gen_pkg.sv
// Shared types and helpers for the contact-bounce press generator.
// Defines the FSM state encoding, the LFSR step and the glitch-width rule.
package bounce_gen_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PB_HI = 3'd1,
        PB_LO = 3'd2,
        HOLD  = 3'd3,
        RB_LO = 3'd4,
        RB_HI = 3'd5,
        GAP   = 3'd6
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // A zero-width segment would stall the press, so zero is promoted to one cycle.
    function automatic logic [15:0] seg_width(input logic [15:0] lfsr, input int glitch_w);
        logic [15:0] mask;
        logic [15:0] w;
        mask = (16'd1 << glitch_w) - 16'd1;
        w    = lfsr & mask;
        if (w == 16'd0) begin
            seg_width = 16'd1;
        end else begin
            seg_width = w;
        end
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        if (v[0]) begin
            lfsr_next = {1'b0, v[15:1]} ^ LFSR_TAPS;
        end else begin
            lfsr_next = {1'b0, v[15:1]};
        end
    endfunction

endpackage

// File: rtl/bounce_press_gen_lfsr16.sv
// 16-bit Galois LFSR that steps only when the press FSM loads a glitch segment.
// A zero seed would lock the register, so it is replaced by a nonzero value.
module lfsr16
    import bounce_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        sysclk,
    input  logic        reset_btn,
    input  logic        advance,
    output logic [15:0] value
);

    localparam logic [15:0] SAFE_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next LFSR value: hold unless a segment load requests one step.
    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge sysclk or posedge reset_btn) begin
        if (reset_btn) begin
            lfsr_q <= SAFE_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/bounce_press_gen.sv
// Emits one bouncy button press per accepted start: press glitches, stable hold,
// release glitches, stable gap. Outputs are registered from the next state.
module bounce_press_gen
    import bounce_gen_pkg::*;
#(
    parameter int          BOUNCE_COUNT = 4,
    parameter int          GLITCH_W     = 5,
    parameter int          HOLD_CYCLES  = 300,
    parameter int          GAP_CYCLES   = 150,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       sysclk,
    input  logic       reset_btn,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       btn_out,
    output logic [3:0] press_count
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = (BOUNCE_COUNT > 1) ? $clog2(BOUNCE_COUNT) : 1;

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] BNC_LAST  = BW'((BOUNCE_COUNT > 0) ? BOUNCE_COUNT - 1 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] seg_cnt_q, seg_cnt_d;
    logic [BW-1:0] bnc_q, bnc_d;
    logic [3:0]    press_q, press_d;
    logic          btn_q, btn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          lfsr_adv;
    logic [15:0]   lfsr_val;
    logic [CW-1:0] glitch_len;
    logic          seg_last;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .sysclk   (sysclk),
        .reset_btn(reset_btn),
        .advance  (lfsr_adv),
        .value    (lfsr_val)
    );

    assign glitch_len = CW'(seg_width(lfsr_val, GLITCH_W));
    assign seg_last   = (seg_cnt_q == CNT_ONE);

    // State, counters and registered outputs.
    always_ff @(posedge sysclk or posedge reset_btn) begin
        if (reset_btn) begin
            state_q   <= IDLE;
            seg_cnt_q <= {CW{1'b0}};
            bnc_q     <= {BW{1'b0}};
            press_q   <= 4'd0;
            btn_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_cnt_q <= seg_cnt_d;
            bnc_q     <= bnc_d;
            press_q   <= press_d;
            btn_q     <= btn_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state: every segment counts down to 1, then loads the following segment.
    always_comb begin
        state_d   = state_q;
        seg_cnt_d = seg_cnt_q;
        bnc_d     = bnc_q;
        lfsr_adv  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (BOUNCE_COUNT == 0)) begin
                    state_d   = HOLD;
                    seg_cnt_d = HOLD_LOAD;
                end else if (start) begin
                    state_d   = PB_HI;
                    seg_cnt_d = glitch_len;
                    lfsr_adv  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
                bnc_d = {BW{1'b0}};
            end
            PB_HI, RB_LO: begin
                if (seg_last) begin
                    state_d   = (state_q == PB_HI) ? PB_LO : RB_HI;
                    seg_cnt_d = glitch_len;
                    lfsr_adv  = 1'b1;
                end else begin
                    seg_cnt_d = seg_cnt_q - CNT_ONE;
                end
            end
            PB_LO, RB_HI: begin
                if (seg_last && (bnc_q == BNC_LAST)) begin
                    state_d   = (state_q == PB_LO) ? HOLD : GAP;
                    seg_cnt_d = (state_q == PB_LO) ? HOLD_LOAD : GAP_LOAD;
                    bnc_d     = {BW{1'b0}};
                end else if (seg_last) begin
                    state_d   = (state_q == PB_LO) ? PB_HI : RB_LO;
                    seg_cnt_d = glitch_len;
                    lfsr_adv  = 1'b1;
                    bnc_d     = bnc_q + BW'(1);
                end else begin
                    seg_cnt_d = seg_cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (seg_last && (BOUNCE_COUNT == 0)) begin
                    state_d   = GAP;
                    seg_cnt_d = GAP_LOAD;
                end else if (seg_last) begin
                    state_d   = RB_LO;
                    seg_cnt_d = glitch_len;
                    lfsr_adv  = 1'b1;
                end else begin
                    seg_cnt_d = seg_cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (seg_last) begin
                    state_d   = IDLE;
                    seg_cnt_d = {CW{1'b0}};
                end else begin
                    seg_cnt_d = seg_cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                seg_cnt_d = {CW{1'b0}};
                bnc_d     = {BW{1'b0}};
            end
        endcase
    end

    // Outputs decoded from the next state so they appear on the transition edge.
    always_comb begin
        btn_d  = 1'b0;
        busy_d = (state_d != IDLE);
        done_d = (state_q == GAP) && (state_d == IDLE);
        case (state_d)
            PB_HI, HOLD, RB_HI: btn_d = 1'b1;
            default:            btn_d = 1'b0;
        endcase
        if (done_d) begin
            press_d = press_q + 4'd1;
        end else begin
            press_d = press_q;
        end
    end

    assign btn_out     = btn_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign press_count = press_q;

endmodule

// File: tb/tb_bounce_press_gen.sv
// Directed bench for bounce_press_gen: run-length checks of btn_out against a
// reference LFSR, async reset mid-press, back-to-back presses, clean-edge and min-width variants.
module tb_bounce_press_gen;

    logic       sysclk = 1'b0;
    logic       reset_btn;
    logic       start_a, start_b, start_c;
    logic       busy_a, done_a, btn_a;
    logic       busy_b, done_b, btn_b;
    logic       busy_c, done_c, btn_c;
    logic [3:0] pc_a, pc_b, pc_c;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int obs_q[$];
    int first_q[$];
    logic [15:0] lf_a;
    logic [15:0] lf_c;

    always #5 sysclk = ~sysclk;

    bounce_press_gen dut_a (
        .sysclk(sysclk), .reset_btn(reset_btn), .start(start_a),
        .busy(busy_a), .done(done_a), .btn_out(btn_a), .press_count(pc_a)
    );

    bounce_press_gen #(.BOUNCE_COUNT(0)) dut_b (
        .sysclk(sysclk), .reset_btn(reset_btn), .start(start_b),
        .busy(busy_b), .done(done_b), .btn_out(btn_b), .press_count(pc_b)
    );

    bounce_press_gen #(.BOUNCE_COUNT(1), .HOLD_CYCLES(20), .GAP_CYCLES(10),
                       .LFSR_SEED(16'h0040)) dut_c (
        .sysclk(sysclk), .reset_btn(reset_btn), .start(start_c),
        .busy(busy_c), .done(done_c), .btn_out(btn_c), .press_count(pc_c)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] v);
        return v[0] ? ({1'b0, v[15:1]} ^ 16'hB400) : {1'b0, v[15:1]};
    endfunction

    function automatic int m_width(input logic [15:0] v);
        int w;
        w = int'(v[4:0]);
        return (w == 0) ? 1 : w;
    endfunction

    // {press_count, done, busy, btn} of the selected instance
    function automatic logic [6:0] outs(input int sel);
        case (sel)
            0:       return {pc_a, done_a, busy_a, btn_a};
            1:       return {pc_b, done_b, busy_b, btn_b};
            default: return {pc_c, done_c, busy_c, btn_c};
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic build_exp(input int bc, input int hold, input int gap, inout logic [15:0] lf);
        exp_q.delete();
        for (int i = 0; i < bc; i++) begin
            exp_q.push_back(m_width(lf)); lf = m_step(lf);
            exp_q.push_back(m_width(lf)); lf = m_step(lf);
        end
        exp_q.push_back(hold);
        for (int i = 0; i < bc; i++) begin
            exp_q.push_back(m_width(lf)); lf = m_step(lf);
            exp_q.push_back(m_width(lf)); lf = m_step(lf);
        end
        exp_q.push_back(gap);
    endtask

    // Starts a press, records btn_out run lengths until done, checks done is a single pulse.
    task automatic run_press(input int sel, input int bound, output int total);
        logic [6:0] o;
        logic       cur;
        int         len;
        int         seen;
        obs_q.delete();
        total = 0;
        seen  = 0;
        @(negedge sysclk);
        set_start(sel, 1'b1);
        @(posedge sysclk);
        #1;
        o = outs(sel);
        check_val($sformatf("busy_at_accept%0d", sel), int'(o[1]), 1);
        check_val($sformatf("btn_at_accept%0d", sel), int'(o[0]), 1);
        set_start(sel, 1'b0);
        cur = 1'b1;
        len = 0;
        while (total < bound) begin
            @(negedge sysclk);
            o = outs(sel);
            if (o[2]) begin
                seen = 1;
                break;
            end
            total++;
            if (o[0] == cur) begin
                len++;
            end else begin
                obs_q.push_back(len);
                cur = o[0];
                len = 1;
            end
        end
        if (len > 0) obs_q.push_back(len);
        check_val($sformatf("done_seen%0d", sel), seen, 1);
        @(negedge sysclk);
        o = outs(sel);
        check_val($sformatf("done_one_cycle%0d", sel), int'(o[2]), 0);
        check_val($sformatf("busy_after_done%0d", sel), int'(o[1]), 0);
    endtask

    task automatic compare_runs(input string tag);
        check_val({tag, "_nruns"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) check_val($sformatf("%s_run%0d", tag, i), obs_q[i], exp_q[i]);
        end
    endtask

    task automatic pulse_reset();
        @(negedge sysclk);
        reset_btn = 1'b1;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        reset_btn = 1'b0;
    endtask

    initial begin
        int tot;
        int wait_n;
        int cnt;
        reset_btn = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        lf_a = 16'hACE1;
        lf_c = 16'h0040;
        repeat (2) @(negedge sysclk);
        reset_btn = 1'b0;
        @(negedge sysclk);
        check_val("rst_btn", int'(btn_a), 0);
        check_val("rst_busy", int'(busy_a), 0);
        check_val("rst_done", int'(done_a), 0);
        check_val("rst_pc", int'(pc_a), 0);

        // First default press from the seed
        build_exp(4, 300, 150, lf_a);
        first_q = exp_q;
        run_press(0, 3000, tot);
        compare_runs("p1");
        check_val("p1_pc", int'(pc_a), 1);

        // Second press, interrupted by reset in the middle of HOLD
        build_exp(4, 300, 150, lf_a);
        wait_n = 100;
        for (int i = 0; i < 8; i++) wait_n += exp_q[i];
        @(negedge sysclk);
        start_a = 1'b1;
        @(posedge sysclk);
        #1;
        start_a = 1'b0;
        repeat (wait_n) @(negedge sysclk);
        check_val("pre_rst_hold_btn", int'(btn_a), 1);
        reset_btn = 1'b1;
        #1;
        check_val("async_rst_btn", int'(btn_a), 0);
        check_val("async_rst_busy", int'(busy_a), 0);
        check_val("async_rst_pc", int'(pc_a), 0);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        reset_btn = 1'b0;
        lf_a = 16'hACE1;

        // After reset the waveform repeats the first press exactly
        exp_q = first_q;
        run_press(0, 3000, tot);
        compare_runs("repro");
        check_val("repro_pc", int'(pc_a), 1);

        // start held high: one press per IDLE visit, back-to-back, counter wraps
        pulse_reset();
        @(negedge sysclk);
        start_a = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cnt = 0;
            while (!done_a && cnt < 2000) begin
                @(negedge sysclk);
                cnt++;
            end
            check_val($sformatf("bb_done%0d", k), int'(done_a), 1);
            check_val($sformatf("bb_pc%0d", k), int'(pc_a), k % 16);
            @(negedge sysclk);
            check_val($sformatf("bb_done_clear%0d", k), int'(done_a), 0);
            check_val($sformatf("bb_restart%0d", k), int'(busy_a), 1);
        end
        start_a = 1'b0;
        cnt = 0;
        while (!done_a && cnt < 2000) begin
            @(negedge sysclk);
            cnt++;
        end
        check_val("bb_last_pc", int'(pc_a), 1);
        @(negedge sysclk);
        check_val("bb_idle", int'(busy_a), 0);

        // Clean edges: 300 high then 150 low, done 450 edges after acceptance
        build_exp(0, 300, 150, lf_a);
        run_press(1, 3000, tot);
        compare_runs("clean");
        check_val("clean_total", tot, 450);
        check_val("clean_pc", int'(pc_b), 1);

        // Seed with zero low bits: first two segments collapse to one cycle
        build_exp(1, 20, 10, lf_c);
        run_press(2, 1000, tot);
        compare_runs("minw");
        if (obs_q.size() > 1) begin
            check_val("minw_first", obs_q[0], 1);
            check_val("minw_second", obs_q[1], 1);
        end else begin
            check_val("minw_runs_present", obs_q.size(), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
